// File: rtl/road_request_collector_pkg.sv
// Shared definitions for the road request collector: road indices, the
// per-road load FSM encoding and counter widths.
package road_request_collector_pkg;

  localparam int NUM_ROADS = 4;

  // Road index constants (bit position in every 4-bit road vector).
  localparam logic [1:0] ROAD_D = 2'd0;
  localparam logic [1:0] ROAD_U = 2'd1;
  localparam logic [1:0] ROAD_L = 2'd2;
  localparam logic [1:0] ROAD_R = 2'd3;

  // Counter widths: debounce counter and cooldown/age counters.
  localparam int DEB_W = 4;
  localparam int CNT_W = 8;

  // Per-road load request FSM.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMING   = 2'd1,
    ST_PENDING  = 2'd2,
    ST_COOLDOWN = 2'd3
  } load_state_e;

endpackage

// File: rtl/road_request_collector_if.sv
// Bus between the sensor front end / signal controller and the collector.
// Handshake: served_valid is a one-cycle strobe qualified by served_road; there
// is no ready -- the collector always accepts a service strobe on the edge it
// is presented, and served_road is ignored whenever served_valid is low.
interface road_request_collector_if;
  import road_request_collector_pkg::*;

  logic [3:0] sense_load;
  logic [3:0] sense_emer;
  logic       served_valid;
  logic [1:0] served_road;
  logic [3:0] p_req;
  logic [3:0] e_req;
  logic [3:0] ack;
  logic [3:0] starve;
  // Packed per-road FSM states, road i in bits [2i+1:2i].
  logic [2*NUM_ROADS-1:0] dbg_state;

  // Driver side: sensors and controller.
  modport master (
    output sense_load, sense_emer, served_valid, served_road,
    input  p_req, e_req, ack, starve, dbg_state
  );

  // Collector side.
  modport slave (
    input  sense_load, sense_emer, served_valid, served_road,
    output p_req, e_req, ack, starve, dbg_state
  );
endinterface

// File: rtl/road_request_collector_slot.sv
// One road: debounced load request FSM with cooldown, wait-age counter,
// emergency latch and service acknowledge.
module road_request_slot
  import road_request_collector_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int COOLDOWN = 8,
  parameter int AGE_MAX  = 200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sense_load,
  input  logic        i_sense_emer,
  input  logic        i_served,
  output logic        o_p_req,
  output logic        o_e_req,
  output logic        o_ack,
  output logic        o_starve,
  output load_state_e o_state
);

  // Last debounce count value before PENDING, last cooldown count value
  // before IDLE, and the age saturation point.
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0] AGE_SAT   = CNT_W'(AGE_MAX);

  load_state_e      r_state, w_state_nxt;
  logic [DEB_W-1:0] r_deb,   w_deb_nxt;
  logic [CNT_W-1:0] r_cool,  w_cool_nxt;
  logic [CNT_W-1:0] r_age,   w_age_nxt;
  logic             r_emer,  w_emer_nxt;
  logic             r_ack,   w_ack_nxt;

  // Next-state logic for the load FSM, its counters, emergency latch and ack.
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb;
    w_cool_nxt  = r_cool;
    w_age_nxt   = r_age;
    // Service clears the emergency latch; clear wins over a new sample.
    w_emer_nxt  = i_served ? 1'b0 : (r_emer | i_sense_emer);
    // Ack only when the service actually cleared something.
    w_ack_nxt   = i_served & ((r_state == ST_PENDING) | r_emer);

    case (r_state)
      ST_IDLE: begin
        if (i_sense_load) begin
          if (DEBOUNCE == 1) begin
            w_state_nxt = ST_PENDING;
            w_deb_nxt   = '0;
            w_age_nxt   = '0;
          end else begin
            w_state_nxt = ST_ARMING;
            w_deb_nxt   = DEB_W'(1);
          end
        end
      end
      ST_ARMING: begin
        if (!i_sense_load) begin
          w_state_nxt = ST_IDLE;
          w_deb_nxt   = '0;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt = ST_PENDING;
          w_deb_nxt   = '0;
          w_age_nxt   = '0;
        end else begin
          w_deb_nxt = r_deb + DEB_W'(1);
        end
      end
      ST_PENDING: begin
        if (i_served) begin
          w_state_nxt = (COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;
          w_cool_nxt  = '0;
          w_age_nxt   = '0;
        end else if (r_age != AGE_SAT) begin
          w_age_nxt = r_age + CNT_W'(1);
        end
      end
      ST_COOLDOWN: begin
        // Sensor ignored until the cooldown window has elapsed.
        if (r_cool == COOL_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cool_nxt  = '0;
        end else begin
          w_cool_nxt = r_cool + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_deb   <= '0;
      r_cool  <= '0;
      r_age   <= '0;
      r_emer  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_deb   <= w_deb_nxt;
      r_cool  <= w_cool_nxt;
      r_age   <= w_age_nxt;
      r_emer  <= w_emer_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign o_p_req  = (r_state == ST_PENDING);
  assign o_e_req  = r_emer;
  assign o_ack    = r_ack;
  assign o_starve = (r_state == ST_PENDING) && (r_age >= AGE_SAT);
  assign o_state  = r_state;

endmodule

// File: rtl/road_request_collector.sv
// Collects debounced load requests and emergency requests from four roads
// and presents them to the signal controller; decodes service strobes.
module road_request_collector
  import road_request_collector_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int COOLDOWN = 8,
  parameter int AGE_MAX  = 200
) (
  input logic                     clk,
  input logic                     rst,
  road_request_collector_if.slave bus
);

  logic [NUM_ROADS-1:0] w_served;
  logic [NUM_ROADS-1:0] w_p_req;
  logic [NUM_ROADS-1:0] w_e_req;
  logic [NUM_ROADS-1:0] w_ack;
  logic [NUM_ROADS-1:0] w_starve;
  load_state_e          w_state [NUM_ROADS];

  for (genvar g = 0; g < NUM_ROADS; g++) begin : g_road
    // Service strobe decoded to the one road it names.
    assign w_served[g] = bus.served_valid && (bus.served_road == 2'(g));

    road_request_slot #(
      .DEBOUNCE (DEBOUNCE),
      .COOLDOWN (COOLDOWN),
      .AGE_MAX  (AGE_MAX)
    ) u_slot (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_sense_load (bus.sense_load[g]),
      .i_sense_emer (bus.sense_emer[g]),
      .i_served     (w_served[g]),
      .o_p_req      (w_p_req[g]),
      .o_e_req      (w_e_req[g]),
      .o_ack        (w_ack[g]),
      .o_starve     (w_starve[g]),
      .o_state      (w_state[g])
    );
  end

  assign bus.p_req     = w_p_req;
  assign bus.e_req     = w_e_req;
  assign bus.ack       = w_ack;
  assign bus.starve    = w_starve;
  assign bus.dbg_state = {w_state[ROAD_R], w_state[ROAD_L],
                          w_state[ROAD_U], w_state[ROAD_D]};

endmodule

// File: tb/tb_road_request_collector.sv
// Bench for road_request_collector with default parameters
// (DEBOUNCE=4, COOLDOWN=8, AGE_MAX=200).
module tb_road_request_collector;

  localparam int DEB  = 4;
  localparam int COOL = 8;
  localparam int AGE  = 200;

  typedef struct {
    logic       rst;
    logic [3:0] load;
    logic [3:0] emer;
    logic       sv;
    logic [1:0] road;
    logic [3:0] p;
    logic [3:0] e;
    logic [3:0] a;
    logic [3:0] s;
  } vec_t;

  logic clk;
  logic rst;
  road_request_collector_if bus ();

  logic [15:0] exp_q[$];
  vec_t        tbl[$];
  int          n_chk;
  int          n_err;

  road_request_collector #(
    .DEBOUNCE (DEB),
    .COOLDOWN (COOL),
    .AGE_MAX  (AGE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic [3:0] l, input logic [3:0] e,
                             input logic sv, input logic [1:0] rd, input logic [3:0] xp,
                             input logic [3:0] xe, input logic [3:0] xa, input logic [3:0] xs);
    vec_t t;
    t.rst = r; t.load = l; t.emer = e; t.sv = sv; t.road = rd;
    t.p = xp; t.e = xe; t.a = xa; t.s = xs;
    return t;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic r, input logic [3:0] l, input logic [3:0] e,
                      input logic sv, input logic [1:0] rd, input logic [15:0] xp,
                      input string tag, input int idx);
    logic [15:0] got;
    logic [15:0] want;
    @(negedge clk);
    rst              = r;
    bus.sense_load   = l;
    bus.sense_emer   = e;
    bus.served_valid = sv;
    bus.served_road  = rd;
    exp_q.push_back(xp);
    @(posedge clk);
    #1;
    got  = {bus.p_req, bus.e_req, bus.ack, bus.starve};
    want = exp_q.pop_front();
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s #%0d: got p=%b e=%b ack=%b starve=%b, want p=%b e=%b ack=%b starve=%b",
               tag, idx, got[15:12], got[11:8], got[7:4], got[3:0],
               want[15:12], want[11:8], want[7:4], want[3:0]);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.sense_load   = '0;
    bus.sense_emer   = '0;
    bus.served_valid = 1'b0;
    bus.served_road  = '0;

    // ---- table: reset, debounce, emergency, service corner cases ----
    //             rst  load     emer     sv  road   p        e        ack      starve
    // reset wins over active sensors and service strobe
    tbl.push_back(v(1, 4'hF,    4'hF,    1, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(1, 4'hF,    4'hF,    1, 2'd2, 4'h0,    4'h0,    4'h0,    4'h0));
    // road 0 high four samples -> pending after 4th edge
    tbl.push_back(v(0, 4'b0001, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0001, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0001, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0001, 4'h0,    0, 2'd0, 4'b0001, 4'h0,    4'h0,    4'h0));
    // serve road 0 -> cleared, one-cycle ack
    tbl.push_back(v(0, 4'h0,    4'h0,    1, 2'd0, 4'h0,    4'h0,    4'b0001, 4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    // road 1: high 3, low 1, high 3 -> never pending
    tbl.push_back(v(0, 4'b0010, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0010, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0010, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0000, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0010, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0010, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0010, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    tbl.push_back(v(0, 4'b0000, 4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    // emergency pulse on road 3, held; wrong-road service ignored; own road clears
    tbl.push_back(v(0, 4'h0,    4'b1000, 0, 2'd0, 4'h0,    4'b1000, 4'h0,    4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    0, 2'd0, 4'h0,    4'b1000, 4'h0,    4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    1, 2'd1, 4'h0,    4'b1000, 4'h0,    4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    1, 2'd3, 4'h0,    4'h0,    4'b1000, 4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));
    // emergency on road 0 concurrent with its service: clear wins, re-sets next
    tbl.push_back(v(0, 4'h0,    4'b0001, 0, 2'd0, 4'h0,    4'b0001, 4'h0,    4'h0));
    tbl.push_back(v(0, 4'h0,    4'b0001, 1, 2'd0, 4'h0,    4'h0,    4'b0001, 4'h0));
    tbl.push_back(v(0, 4'h0,    4'b0001, 0, 2'd0, 4'h0,    4'b0001, 4'h0,    4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    0, 2'd0, 4'h0,    4'b0001, 4'h0,    4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    1, 2'd0, 4'h0,    4'h0,    4'b0001, 4'h0));
    tbl.push_back(v(0, 4'h0,    4'h0,    0, 2'd0, 4'h0,    4'h0,    4'h0,    4'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].load, tbl[i].emer, tbl[i].sv, tbl[i].road,
           {tbl[i].p, tbl[i].e, tbl[i].a, tbl[i].s}, "table", i);
    end

    // ---- road 2: service with sensor held high, re-arm after cooldown ----
    for (int k = 1; k <= DEB; k++) begin
      step(0, 4'b0100, 4'h0, 0, 2'd0,
           {((k == DEB) ? 4'b0100 : 4'h0), 4'h0, 4'h0, 4'h0}, "arm_r2", k);
    end
    step(0, 4'b0100, 4'h0, 1, 2'd2, {4'h0, 4'h0, 4'b0100, 4'h0}, "serve_r2", 0);
    for (int k = 1; k <= COOL + DEB; k++) begin
      step(0, 4'b0100, 4'h0, 0, 2'd0,
           {((k == COOL + DEB) ? 4'b0100 : 4'h0), 4'h0, 4'h0, 4'h0}, "rearm_r2", k);
    end
    step(0, 4'h0, 4'h0, 1, 2'd2, {4'h0, 4'h0, 4'b0100, 4'h0}, "serve_r2b", 0);
    step(0, 4'h0, 4'h0, 0, 2'd0, {4'h0, 4'h0, 4'h0, 4'h0}, "idle_r2", 0);

    // ---- road 1: starvation after AGE_MAX cycles in PENDING, no wrap ----
    for (int k = 1; k <= DEB; k++) begin
      step(0, 4'b0010, 4'h0, 0, 2'd0,
           {((k == DEB) ? 4'b0010 : 4'h0), 4'h0, 4'h0, 4'h0}, "arm_r1", k);
    end
    for (int k = 1; k <= 250; k++) begin
      // Sensor level is irrelevant once pending; random levels on road 1.
      step(0, {2'b00, 1'($urandom_range(0, 1)), 1'b0}, 4'h0, 0, 2'd0,
           {4'b0010, 4'h0, 4'h0, ((k >= AGE) ? 4'b0010 : 4'h0)}, "age_r1", k);
    end
    step(0, 4'h0, 4'h0, 1, 2'd1, {4'h0, 4'h0, 4'b0010, 4'h0}, "serve_r1", 0);

    // ---- roads 0 and 3: reset mid-arming discards progress ----
    for (int k = 1; k <= 3; k++) begin
      step(0, 4'b1001, 4'h0, 0, 2'd0, {4'h0, 4'h0, 4'h0, 4'h0}, "arm_r03", k);
    end
    step(1, 4'b1001, 4'h0, 0, 2'd0, {4'h0, 4'h0, 4'h0, 4'h0}, "rst_mid", 0);
    for (int k = 1; k <= DEB; k++) begin
      // A service strobe during ARMING must not disturb the FSM.
      step(0, 4'b1001, 4'h0, (k == 2), 2'd0,
           {((k == DEB) ? 4'b1001 : 4'h0), 4'h0, 4'h0, 4'h0}, "post_rst", k);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
